// File: rtl/mealy_serial_sequencer.sv
// Serialises a parallel word LSB-first into an external Mealy next-state block, owns its state
// register and returns the number of entries into state 11. Optional macro: WORD_RESTART_EN.
module mealy_serial_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             fsm_w,
    output logic             fsm_y1,
    output logic             fsm_y2,
    input  logic             fsm_Y1,
    input  logic             fsm_Y2,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    input  logic             out_ready
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0]   LAST_BIT = BCW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ctrl_e;

    ctrl_e            ctrl_q, ctrl_d;
    logic [1:0]       y_q, y_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= IDLE;
            y_q       <= 2'b00;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            hit_cnt_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            y_q       <= y_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        y_d       = y_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        hit_cnt_d = hit_cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        fsm_w     = 1'b0;

        case (ctrl_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
                    hit_cnt_d = '0;
`ifdef WORD_RESTART_EN
                    y_d       = 2'b00;
`endif
                    ctrl_d    = SHIFT;
                end
            end
            SHIFT: begin
                // The external next-state logic is only trusted while a bit is being presented.
                fsm_w     = shreg_q[0];
                y_d       = {fsm_Y1, fsm_Y2};
                if (y_d == 2'b11 && hit_cnt_q != CNT_MAX) begin
                    hit_cnt_d = hit_cnt_q + CNT_W'(1);
                end
                shreg_d   = shreg_q >> 1;
                bit_cnt_d = bit_cnt_q + BCW'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    ctrl_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    ctrl_d = IDLE;
                end
            end
            default: ctrl_d = IDLE;
        endcase
    end

    assign fsm_y1    = y_q[1];
    assign fsm_y2    = y_q[0];
    assign out_count = (ctrl_q == DONE) ? hit_cnt_q : '0;

endmodule

// File: tb/tb_mealy_serial_sequencer.sv
// Scoreboard bench: drives words into two sequencers (CNT_W=4 and CNT_W=1), each closed around
// a behavioural next-state block, and compares counts, end state, serial bits and handshakes.
module tb_mealy_serial_sequencer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_ready;

    logic             in_ready, fsm_w, fsm_y1, fsm_y2, fsm_Y1, fsm_Y2, out_valid;
    logic [3:0]       out_count;
    logic             sat_in_ready, sat_w, sat_y1, sat_y2, sat_Y1, sat_Y2, sat_out_valid;
    logic [0:0]       sat_out_count;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [WIDTH-1:0] word;
        int               cnt;
        int               cnt_sat;
        logic [1:0]       end_state;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] model_state;

    always #5 clk = ~clk;

    // Behavioural stand-in for the external next-state logic ("110" detector from 00).
    function automatic logic [1:0] nextState(input logic [1:0] s, input logic w);
        case (s)
            2'b00:   return w ? 2'b01 : 2'b00;
            2'b01:   return w ? 2'b10 : 2'b00;
            2'b10:   return w ? 2'b00 : 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    assign {fsm_Y1, fsm_Y2} = nextState({fsm_y1, fsm_y2}, fsm_w);
    assign {sat_Y1, sat_Y2} = nextState({sat_y1, sat_y2}, sat_w);

    mealy_serial_sequencer #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .fsm_w(fsm_w), .fsm_y1(fsm_y1), .fsm_y2(fsm_y2), .fsm_Y1(fsm_Y1), .fsm_Y2(fsm_Y2),
        .out_valid(out_valid), .out_count(out_count), .out_ready(out_ready)
    );

    mealy_serial_sequencer #(.WIDTH(WIDTH), .CNT_W(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(sat_in_ready),
        .fsm_w(sat_w), .fsm_y1(sat_y1), .fsm_y2(sat_y2), .fsm_Y1(sat_Y1), .fsm_Y2(sat_Y2),
        .out_valid(sat_out_valid), .out_count(sat_out_count), .out_ready(out_ready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Called #1 after a rising edge with the DUT in IDLE; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] word);
        exp_t       e;
        logic [1:0] s;
        int         hits = 0;
`ifdef WORD_RESTART_EN
        model_state = 2'b00;
`endif
        s = model_state;
        for (int i = 0; i < WIDTH; i++) begin
            s = nextState(s, word[i]);
            if (s == 2'b11) hits++;
        end
        e.word      = word;
        e.cnt       = (hits > 15) ? 15 : hits;
        e.cnt_sat   = (hits > 1) ? 1 : hits;
        e.end_state = s;
        model_state = s;
        exp_q.push_back(e);
        checkOutput("in_ready_idle", in_ready, 1);
        in_data  = word;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic collectResult(input int stall);
        exp_t e;
        int   cyc = 0;
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        while (!out_valid && cyc < 4 * WIDTH) begin
            if (cyc < WIDTH) checkOutput($sformatf("fsm_w_bit%0d", cyc), fsm_w, e.word[cyc]);
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("latency", cyc, WIDTH);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        repeat (stall) begin
            checkOutput("stall_count", out_count, e.cnt);
            checkOutput("stall_in_ready", in_ready, 0);
            checkOutput("stall_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
        checkOutput("out_count", out_count, e.cnt);
        checkOutput("out_count_sat", sat_out_count, e.cnt_sat);
        checkOutput("sat_valid", sat_out_valid, 1);
        checkOutput("end_state", {fsm_y1, fsm_y2}, e.end_state);
        checkOutput("fsm_w_done", fsm_w, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("released_valid", out_valid, 0);
        checkOutput("released_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        model_state = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_count", out_count, 0);
        checkOutput("rst_fsm_w", fsm_w, 0);
        checkOutput("rst_state", {fsm_y1, fsm_y2}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(8'h03); collectResult(0);
        applyStimulus(8'h00); collectResult(0);
        applyStimulus(8'hDB); collectResult(1);
        applyStimulus(8'h00); collectResult(0);
        applyStimulus(8'h33); collectResult(5);
        applyStimulus(8'h36); collectResult(2);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(WIDTH'($urandom_range(0, 255)));
            collectResult(i % 3);
        end

        // Abandon a word while the fourth bit is on fsm_w.
        applyStimulus(8'h0B);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre_rst_fsm_w", fsm_w, 1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_in_ready", in_ready, 1);
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_out_count", out_count, 0);
        checkOutput("mid_rst_fsm_w", fsm_w, 0);
        checkOutput("mid_rst_state", {fsm_y1, fsm_y2}, 0);
        void'(exp_q.pop_front());
        model_state = 2'b00;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (2 * WIDTH) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("no_valid_after_rst", seen, 0);
        applyStimulus(8'h03); collectResult(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
